// File: rtl/dsa_control_fsm_simd_pipe.sv
// SIMD group sequencer for the bilinear DSA: masked row tails, write backpressure, abort.
// Define DSA_PREFETCH_EN to overlap the fetch of group n+1 with dp/write of group n.
module dsa_control_fsm_simd_pipe #(
    parameter int SIMD_WIDTH     = 4,
    parameter int IMG_WIDTH_MAX  = 512,
    parameter int IMG_HEIGHT_MAX = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  abort,
    input  logic [15:0]           img_width_out,
    input  logic [15:0]           img_height_out,
    output logic                  fetch_req,
    output logic [15:0]           fetch_x,
    output logic [15:0]           fetch_y,
    input  logic                  fetch_done,
    output logic                  dp_start,
    input  logic                  dp_done,
    output logic                  wr_req,
    input  logic                  wr_ready,
    output logic [SIMD_WIDTH-1:0] lane_mask,
    output logic [15:0]           current_x,
    output logic [15:0]           current_y,
    output logic                  busy,
    output logic                  ready,
    output logic                  err
);
    localparam int          SW_LOG = $clog2(SIMD_WIDTH);
    localparam logic [16:0] STEP   = 17'(SIMD_WIDTH);
    localparam logic [31:0] ROUND  = 32'(SIMD_WIDTH - 1);
    localparam logic [15:0] W_MAX  = 16'(IMG_WIDTH_MAX);
    localparam logic [15:0] H_MAX  = 16'(IMG_HEIGHT_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;

    typedef struct packed {
        logic                  fetch_req;
        logic [15:0]           fetch_x;
        logic [15:0]           fetch_y;
        logic                  dp_start;
        logic                  wr_req;
        logic [SIMD_WIDTH-1:0] lane_mask;
        logic [15:0]           current_x;
        logic [15:0]           current_y;
        logic [15:0]           w;
        logic [15:0]           buf_x;
        logic [15:0]           buf_y;
        logic [31:0]           total;
        logic [31:0]           issued;
        logic [31:0]           written;
        logic                  fetch_out;
        logic                  fbuf_full;
        logic                  dp_busy;
    } ctl_t;

    state_t state, state_nxt;
    ctl_t   r, n;

    logic        dims_bad, fd, dd, hs, last_hs, launch, issue, issue_ok;
    logic [31:0] total_in;
    logic [15:0] src_x, src_y;
    logic [16:0] fx_step;
    logic [SIMD_WIDTH-1:0] mask_nxt;

    assign dims_bad = (img_width_out == 16'd0) || (img_width_out > W_MAX) ||
                      (img_height_out == 16'd0) || (img_height_out > H_MAX);
    assign total_in = ((32'(img_width_out) + ROUND) >> SW_LOG) * 32'(img_height_out);

    assign fd      = (state == RUN) && fetch_done && r.fetch_out;
    assign dd      = (state == RUN) && dp_done && r.dp_busy;
    assign hs      = r.wr_req && wr_ready;
    assign last_hs = hs && (r.written + 32'd1 == r.total);
    // An empty buffer lets a returning group go straight to the datapath.
    assign launch  = (state == RUN) && (r.fbuf_full || fd) && !r.dp_busy && !r.wr_req;
    assign src_x   = r.fbuf_full ? r.buf_x : r.fetch_x;
    assign src_y   = r.fbuf_full ? r.buf_y : r.fetch_y;
    assign fx_step = 17'(r.fetch_x) + STEP;
`ifdef DSA_PREFETCH_EN
    assign issue_ok = 1'b1;
`else
    assign issue_ok = !r.dp_busy && !r.wr_req;
`endif
    assign issue = (state == RUN) && !r.fetch_out && !r.fbuf_full && issue_ok &&
                   (r.issued < r.total);

    always_comb begin
        mask_nxt = '0;
        for (int i = 0; i < SIMD_WIDTH; i++)
            mask_nxt[i] = (17'(src_x) + 17'(i)) < 17'(r.w);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (enable) state_nxt = dims_bad ? ERROR : RUN;
            RUN:         if (abort) state_nxt = IDLE;
                         else if (last_hs) state_nxt = DONE;
            DONE, ERROR: if (!enable) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        n = r;
        n.fetch_req = 1'b0;
        n.dp_start  = 1'b0;
        if (state != RUN || abort) begin
            n = '0;
            if (state == IDLE && enable && !dims_bad) begin
                n.w         = img_width_out;
                n.total     = total_in;
                n.fetch_req = 1'b1;
                n.fetch_out = 1'b1;
                n.issued    = 32'd1;
            end
        end else begin
            if (issue) begin
                n.fetch_req = 1'b1;
                n.fetch_out = 1'b1;
                n.issued    = r.issued + 32'd1;
            end
            if (fd) begin
                n.fetch_out = 1'b0;
                n.buf_x     = r.fetch_x;
                n.buf_y     = r.fetch_y;
                if (fx_step < 17'(r.w)) n.fetch_x = fx_step[15:0];
                else begin
                    n.fetch_x = '0;
                    n.fetch_y = r.fetch_y + 16'd1;
                end
            end
            // Buffer ends full if it refills, or if it was full and nothing drained it.
            n.fbuf_full = fd ? (r.fbuf_full || !launch) : (r.fbuf_full && !launch);
            if (launch) begin
                n.dp_start  = 1'b1;
                n.dp_busy   = 1'b1;
                n.current_x = src_x;
                n.current_y = src_y;
                n.lane_mask = mask_nxt;
            end
            if (dd) begin
                n.dp_busy = 1'b0;
                n.wr_req  = 1'b1;
            end
            if (hs) begin
                n.wr_req  = 1'b0;
                n.written = r.written + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r <= '0;
        else     r <= n;
    end

    assign fetch_req = r.fetch_req;
    assign fetch_x   = r.fetch_x;
    assign fetch_y   = r.fetch_y;
    assign dp_start  = r.dp_start;
    assign wr_req    = r.wr_req;
    assign lane_mask = r.lane_mask;
    assign current_x = r.current_x;
    assign current_y = r.current_y;
    assign busy      = (state == RUN);
    assign ready     = (state == DONE);
    assign err       = (state == ERROR);
endmodule

// File: tb/tb_dsa_control_fsm_simd_pipe.sv
// Directed bench for dsa_control_fsm_simd_pipe with latency-programmable fetch/dp responders.
module tb_dsa_control_fsm_simd_pipe;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst, enable, abort, fetch_done, dp_done, wr_ready;
    logic [15:0]   img_w, img_h;
    logic          fetch_req, dp_start, wr_req, busy, ready, err;
    logic [15:0]   fetch_x, fetch_y, current_x, current_y;
    logic [SW-1:0] lane_mask;

    int n_assert = 0, n_fail = 0;
    int f_lat = 1, d_lat = 1;
    int ng = 0, nw = 0, nf = 0;
    logic [15:0]   gx [16];
    logic [15:0]   gy [16];
    logic [SW-1:0] gm [16];

    always #5 clk = ~clk;

    dsa_control_fsm_simd_pipe #(.SIMD_WIDTH(SW), .IMG_WIDTH_MAX(512), .IMG_HEIGHT_MAX(512)) dut (
        .clk(clk), .rst(rst), .enable(enable), .abort(abort),
        .img_width_out(img_w), .img_height_out(img_h),
        .fetch_req(fetch_req), .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_done(fetch_done),
        .dp_start(dp_start), .dp_done(dp_done), .wr_req(wr_req), .wr_ready(wr_ready),
        .lane_mask(lane_mask), .current_x(current_x), .current_y(current_y),
        .busy(busy), .ready(ready), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, input int lim);
        int k = 0;
        while (ready !== 1'b1 && k < lim) begin tick(); k++; end
        chk(tag, 32'(ready), 32'd1);
    endtask

    task automatic wait_wr(input string tag, input int lim);
        int k = 0;
        while (wr_req !== 1'b1 && k < lim) begin tick(); k++; end
        chk(tag, 32'(wr_req), 32'd1);
    endtask

    task automatic chk_grp(input int i, input logic [15:0] x, input logic [15:0] y,
                           input logic [SW-1:0] m);
        chk($sformatf("grp%0d_x", i), 32'(gx[i]), 32'(x));
        chk($sformatf("grp%0d_y", i), 32'(gy[i]), 32'(y));
        chk($sformatf("grp%0d_mask", i), 32'(gm[i]), 32'(m));
    endtask

    task automatic clr_log();
        ng = 0; nw = 0; nf = 0;
    endtask

    // Fetch responder: fetch_done f_lat cycles after the fetch_req cycle.
    initial begin : fetch_resp
        int cnt = 0;
        fetch_done = 1'b0;
        forever begin
            @(negedge clk);
            fetch_done = 1'b0;
            if (cnt > 0) begin cnt--; if (cnt == 0) fetch_done = 1'b1; end
            if (fetch_req === 1'b1) begin
                if (f_lat == 0) fetch_done = 1'b1; else cnt = f_lat;
            end
        end
    end

    initial begin : dp_resp
        int cnt = 0;
        dp_done = 1'b0;
        forever begin
            @(negedge clk);
            dp_done = 1'b0;
            if (cnt > 0) begin cnt--; if (cnt == 0) dp_done = 1'b1; end
            if (dp_start === 1'b1) begin
                if (d_lat == 0) dp_done = 1'b1; else cnt = d_lat;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk); #1;
            if (dp_start === 1'b1 && ng < 16) begin
                gx[ng] = current_x; gy[ng] = current_y; gm[ng] = lane_mask; ng++;
            end
            if (wr_req === 1'b1 && wr_ready === 1'b1) nw++;
            if (fetch_req === 1'b1) nf++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; abort = 1'b0; wr_ready = 1'b1;
        img_w = 16'd8; img_h = 16'd2;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_fetch_req", 32'(fetch_req), 0);
        chk("rst_wr_req", 32'(wr_req), 0);
        chk("rst_lane_mask", 32'(lane_mask), 0);
        chk("rst_current_x", 32'(current_x), 0);
        tick(); rst = 1'b0; tick(); tick();

        // W=8 H=2: four full groups, serial responders of latency 1
        clr_log(); enable = 1'b1;
        tick();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_fetch_req", 32'(fetch_req), 1);
        chk("t1_fetch_x", 32'(fetch_x), 0);
        chk("t1_fetch_y", 32'(fetch_y), 0);
        wait_ready("t1_ready", 200);
        chk("t1_err", 32'(err), 0);
        chk("t1_writes", 32'(nw), 4);
        chk("t1_groups", 32'(ng), 4);
        chk("t1_fetches", 32'(nf), 4);
        chk_grp(0, 16'd0, 16'd0, 4'b1111);
        chk_grp(1, 16'd4, 16'd0, 4'b1111);
        chk_grp(2, 16'd0, 16'd1, 4'b1111);
        chk_grp(3, 16'd4, 16'd1, 4'b1111);
        enable = 1'b0; tick();
        chk("t1_back_idle", 32'(ready), 0);

        // W=10 H=1: partial tail group
        clr_log(); img_w = 16'd10; img_h = 16'd1; enable = 1'b1;
        wait_ready("t2_ready", 200);
        chk("t2_writes", 32'(nw), 3);
        chk("t2_groups", 32'(ng), 3);
        chk_grp(0, 16'd0, 16'd0, 4'b1111);
        chk_grp(1, 16'd4, 16'd0, 4'b1111);
        chk_grp(2, 16'd8, 16'd0, 4'b0011);
        enable = 1'b0; tick();

        // Backpressure: fetch latency 3, dp latency 5, write stalled for 10 cycles
        clr_log(); f_lat = 3; d_lat = 5; wr_ready = 1'b0;
        img_w = 16'd8; img_h = 16'd2; enable = 1'b1;
        wait_wr("t3_wr_req_rise", 100);
`ifdef DSA_PREFETCH_EN
        chk("t3_prefetch_count", 32'(nf), 2);
        chk("t3_fetch_ptr_x", 32'(fetch_x), 0);
        chk("t3_fetch_ptr_y", 32'(fetch_y), 1);
`else
        chk("t3_serial_count", 32'(nf), 1);
        chk("t3_fetch_ptr_x", 32'(fetch_x), 4);
        chk("t3_fetch_ptr_y", 32'(fetch_y), 0);
`endif
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_hold_wr_req_%0d", i), 32'(wr_req), 1);
            chk($sformatf("t3_no_dp_start_%0d", i), 32'(dp_start), 0);
            chk($sformatf("t3_no_fetch_req_%0d", i), 32'(fetch_req), 0);
            tick();
        end
        wr_ready = 1'b1;
        wait_ready("t3_ready", 300);
        chk("t3_writes", 32'(nw), 4);
        chk("t3_groups", 32'(ng), 4);
        chk_grp(1, 16'd4, 16'd0, 4'b1111);
        chk_grp(3, 16'd4, 16'd1, 4'b1111);
        enable = 1'b0; f_lat = 1; d_lat = 1; tick();

        // Dimension errors and MAX boundaries
        clr_log(); img_w = 16'd0; img_h = 16'd4; enable = 1'b1;
        tick();
        chk("t4_w0_err", 32'(err), 1);
        chk("t4_w0_busy", 32'(busy), 0);
        tick();
        chk("t4_w0_no_fetch", 32'(nf), 0);
        enable = 1'b0; tick();
        chk("t4_w0_cleared", 32'(err), 0);
        img_w = 16'd8; img_h = 16'd600; enable = 1'b1;
        tick();
        chk("t4_h600_err", 32'(err), 1);
        enable = 1'b0; tick();
        chk("t4_h600_cleared", 32'(err), 0);
        img_w = 16'd513; img_h = 16'd1; enable = 1'b1;
        tick();
        chk("t4_w513_err", 32'(err), 1);
        enable = 1'b0; tick();
        img_w = 16'd512; img_h = 16'd512; enable = 1'b1;
        tick();
        chk("t4_max_busy", 32'(busy), 1);
        chk("t4_max_err", 32'(err), 0);
        abort = 1'b1; enable = 1'b0; tick();
        abort = 1'b0;
        chk("t4_max_aborted", 32'(busy), 0);
        tick(); tick();

        // Abort with a fetch outstanding; the late fetch_done must be ignored
        clr_log(); f_lat = 6; img_w = 16'd8; img_h = 16'd2; enable = 1'b1;
        tick(); tick(); tick();
        chk("t5_running", 32'(busy), 1);
        abort = 1'b1; enable = 1'b0; tick();
        abort = 1'b0;
        chk("t5_abort_busy", 32'(busy), 0);
        chk("t5_abort_fetch_y", 32'(fetch_y), 0);
        chk("t5_abort_fetch_req", 32'(fetch_req), 0);
        for (int i = 0; i < 8; i++) tick();
        chk("t5_late_done_ignored", 32'(ng), 0);
        chk("t5_still_idle", 32'(busy), 0);
        clr_log(); f_lat = 1; enable = 1'b1;
        tick();
        chk("t5_restart_fetch_req", 32'(fetch_req), 1);
        chk("t5_restart_x", 32'(fetch_x), 0);
        chk("t5_restart_y", 32'(fetch_y), 0);
        wait_ready("t5_ready", 200);
        chk("t5_writes", 32'(nw), 4);
        chk_grp(0, 16'd0, 16'd0, 4'b1111);
        enable = 1'b0; tick();

        // Asynchronous reset during a pending write
        img_w = 16'd10; img_h = 16'd1; wr_ready = 1'b0; enable = 1'b1;
        wait_wr("t6_wr_req", 100);
        chk("t6_pre_mask", 32'(lane_mask), 32'h0000_000F);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_wr_req", 32'(wr_req), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_mask", 32'(lane_mask), 0);
        chk("t6_rst_fetch_x", 32'(fetch_x), 0);
        chk("t6_rst_current_x", 32'(current_x), 0);
        enable = 1'b0; wr_ready = 1'b1;
        tick(); rst = 1'b0; tick(); tick();
        chk("t6_idle_busy", 32'(busy), 0);
        chk("t6_idle_ready", 32'(ready), 0);
        chk("t6_idle_err", 32'(err), 0);
        chk("t6_idle_fetch_req", 32'(fetch_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
